// File: rtl/rs_relay_pkg.sv
// Shared constants and elaboration helpers for the relay station and its tail buffer.
package rs_relay_pkg;

  localparam int DEFAULT_LEVEL      = 2;
  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int MAX_LEVEL          = 8;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The tail buffer must absorb LEVEL words in flight plus LEVEL cycles of stale full_n.
  function automatic bit depth_ok(input int depth, input int level);
    return (level >= 0) && (level <= MAX_LEVEL) && (depth >= 2 * level + 2);
  endfunction

endpackage

// File: rtl/rs_relay_fifo.sv
// First-word-fall-through tail buffer with registered count and registered full/empty flags.
module rs_relay_fifo
  import rs_relay_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            i_rst_n,
  input  logic                            i_push,
  input  logic [DATA_WIDTH-1:0]           i_din,
  input  logic                            i_pop,
  output logic [DATA_WIDTH-1:0]           o_dout,
  output logic                            o_empty_n,
  output logic                            o_full,
  output logic [count_width(DEPTH)-1:0]   o_count
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_next;
  logic                  r_empty_n;
  logic                  r_full;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop  = i_pop & r_empty_n;
  // A push into a full buffer is only legal when the head leaves on the same edge.
  assign w_push = i_push & (~r_full | w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty_n <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count   <= w_count_next;
      r_empty_n <= (w_count_next != '0);
      r_full    <= (w_count_next == FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout    = r_mem[r_rd_ptr];
  assign o_empty_n = r_empty_n;
  assign o_full    = r_full;
  assign o_count   = r_count;

endmodule

// File: rtl/rs_relay_station.sv
// Relay station: LEVEL forward data/valid registers, LEVEL backward space registers,
// and a tail buffer sized to absorb everything issued against a stale full_n.
module rs_relay_station
  import rs_relay_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL      = DEFAULT_LEVEL,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read
);

  localparam int CW = count_width(FIFO_DEPTH);
  localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - 2 * LEVEL - 2);

  generate
    if (!depth_ok(FIFO_DEPTH, LEVEL)) begin : g_param_error
      $error("rs_relay_station: need LEVEL in 0..8 and FIFO_DEPTH >= 2*LEVEL+2");
    end
  endgenerate

  logic                  w_accept;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [CW-1:0]         w_count;
  logic                  w_fifo_full;
  logic                  w_space_ok;

  assign w_accept   = if_write & if_full_n;
  assign w_space_ok = ~w_fifo_full & (w_count <= SPACE_LIMIT);

  generate
    if (LEVEL == 0) begin : g_fwd_direct
      assign w_push      = w_accept;
      assign w_push_data = if_din;
    end else begin : g_fwd_pipe
      logic [LEVEL-1:0]      r_fwd_valid;
      logic [DATA_WIDTH-1:0] r_fwd_data [LEVEL];

      always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_fwd_valid <= '0;
        end else begin
          r_fwd_valid[0] <= w_accept;
          for (int i = 1; i < LEVEL; i++) begin
            r_fwd_valid[i] <= r_fwd_valid[i-1];
          end
        end
      end

      // Payload rides alongside valid; it is only meaningful where valid is set.
      always_ff @(posedge clk) begin
        r_fwd_data[0] <= if_din;
        for (int i = 1; i < LEVEL; i++) begin
          r_fwd_data[i] <= r_fwd_data[i-1];
        end
      end

      assign w_push      = r_fwd_valid[LEVEL-1];
      assign w_push_data = r_fwd_data[LEVEL-1];
    end

    if (LEVEL == 0) begin : g_bwd_direct
      // Holds full_n low until the first edge after reset release.
      logic r_alive;
      always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_alive <= 1'b0;
        end else begin
          r_alive <= 1'b1;
        end
      end
      assign if_full_n = r_alive & w_space_ok;
    end else begin : g_bwd_pipe
      logic [LEVEL-1:0] r_space;
      always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_space <= '0;
        end else begin
          r_space[0] <= w_space_ok;
          for (int i = 1; i < LEVEL; i++) begin
            r_space[i] <= r_space[i-1];
          end
        end
      end
      assign if_full_n = r_space[LEVEL-1];
    end
  endgenerate

  rs_relay_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .i_rst_n   (ap_rst_n),
    .i_push    (w_push),
    .i_din     (w_push_data),
    .i_pop     (if_read),
    .o_dout    (if_dout),
    .o_empty_n (if_empty_n),
    .o_full    (w_fifo_full),
    .o_count   (w_count)
  );

endmodule

// File: tb/tb_rs_relay_station.sv
// Bench: directed vector table and corner sequences on a LEVEL=2 station, plus
// randomized traffic on four stations checked against a timing-aware queue model.
`timescale 1ns/1ps
module tb_rs_relay_station;

  localparam int DW          = 32;
  localparam int NRAND       = 4;
  localparam int RAND_CYCLES = 10000;
  localparam int NVEC        = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        exp_full_n;
    logic        exp_empty_n;
    logic [31:0] exp_dout;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          arrive;
  } ent_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] din, input logic rd,
                              input logic f, input logic e, input logic [31:0] d);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd;
    v.exp_full_n = f; v.exp_empty_n = e; v.exp_dout = d;
    return v;
  endfunction

  // Directed station: LEVEL=2, FIFO_DEPTH=8
  logic          m_rst_n, m_wr, m_rd, m_full_n, m_empty_n;
  logic [DW-1:0] m_din, m_dout;

  rs_relay_station #(.DATA_WIDTH(DW), .LEVEL(2), .FIFO_DEPTH(8)) u_dut (
    .clk        (clk),
    .ap_rst_n   (m_rst_n),
    .if_din     (m_din),
    .if_write   (m_wr),
    .if_full_n  (m_full_n),
    .if_dout    (m_dout),
    .if_empty_n (m_empty_n),
    .if_read    (m_rd)
  );

  task automatic m_reset();
    @(negedge clk);
    m_rst_n = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_rst_n = 1'b1;
  endtask

  // Randomized stations
  for (genvar gi = 0; gi < NRAND; gi++) begin : g_rand
    localparam int L     = (gi == 0) ? 0 : (gi == 1) ? 1 : (gi == 2) ? 3 : 2;
    localparam int D     = (gi == 2) ? 10 : 8;
    localparam int LIMIT = D - 2 * L - 2;

    logic        rst_n, wr, rd, full_n, empty_n, done;
    logic [15:0] din, dout;
    ent_t        q[$];
    int          occ_hist [0:RAND_CYCLES];

    rs_relay_station #(.DATA_WIDTH(16), .LEVEL(L), .FIFO_DEPTH(D)) u_dut (
      .clk        (clk),
      .ap_rst_n   (rst_n),
      .if_din     (din),
      .if_write   (wr),
      .if_full_n  (full_n),
      .if_dout    (dout),
      .if_empty_n (empty_n),
      .if_read    (rd)
    );

    initial begin
      int          occ;
      int          accepted;
      int          popped;
      logic        exp_full;
      logic        exp_empty;
      logic [15:0] exp_dout;
      ent_t        ent;
      done = 1'b0; rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
      accepted = 0; popped = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_full = 1'b0; exp_empty = 1'b0; exp_dout = '0;
      occ_hist[0] = 0;
      for (int e = 1; e <= RAND_CYCLES; e++) begin
        wr  = 1'($urandom_range(0, 1));
        rd  = 1'($urandom_range(0, 1));
        din = 16'($urandom);
        @(posedge clk);
        // Model: a word accepted at edge e lands in the buffer at edge e+L.
        if (rd && exp_empty) begin
          void'(q.pop_front());
          popped++;
        end
        if (wr && exp_full) begin
          ent.data = din;
          ent.arrive = e + L;
          q.push_back(ent);
          accepted++;
        end
        occ = 0;
        foreach (q[j]) if (q[j].arrive <= e) occ++;
        occ_hist[e] = occ;
        exp_empty = (occ > 0);
        if (exp_empty) exp_dout = q[0].data;
        exp_full = 1'b0;
        if (e >= ((L == 0) ? 1 : L)) exp_full = (occ_hist[e-L] <= LIMIT);
        #1;
        check($sformatf("L%0d cyc%0d empty_n", L, e), empty_n, exp_empty);
        check($sformatf("L%0d cyc%0d full_n", L, e), full_n, exp_full);
        check($sformatf("L%0d cyc%0d count", L, e), u_dut.u_fifo.r_count, occ);
        if (exp_empty) check($sformatf("L%0d cyc%0d dout", L, e), dout, exp_dout);
        @(negedge clk);
      end
      wr = 1'b0; rd = 1'b0;
      $display("random LEVEL=%0d DEPTH=%0d: %0d accepted, %0d popped", L, D, accepted, popped);
      done = 1'b1;
    end
  end

  vec_t vecs [NVEC];

  initial begin
    int   nxt, got, first_out, last_out, acc0, max_cnt;
    logic saw_high, saw_low;
    n_cmp = 0; n_bad = 0;
    m_rst_n = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_din = '0;

    vecs[0]  = mk(0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(1, 32'hA5A5A5A5, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 1, 32'hA5A5A5A5);
    vecs[7]  = mk(0, 0, 0, 1, 1, 32'hA5A5A5A5);
    vecs[8]  = mk(0, 0, 1, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 0);
    vecs[10] = mk(1, 1, 0, 1, 0, 0);
    vecs[11] = mk(1, 2, 0, 1, 0, 0);
    vecs[12] = mk(1, 3, 0, 1, 1, 1);
    vecs[13] = mk(0, 0, 0, 1, 1, 1);
    vecs[14] = mk(0, 0, 0, 1, 1, 1);
    vecs[15] = mk(0, 0, 0, 1, 1, 1);
    vecs[16] = mk(0, 0, 0, 0, 1, 1);
    vecs[17] = mk(1, 32'hDEAD, 1, 0, 1, 2);
    vecs[18] = mk(1, 32'hDEAD, 1, 0, 1, 3);
    vecs[19] = mk(1, 32'hDEAD, 1, 1, 0, 0);
    vecs[20] = mk(0, 0, 0, 1, 0, 0);
    vecs[21] = mk(0, 0, 1, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset empty_n", m_empty_n, 0);
    check("reset full_n", m_full_n, 0);
    @(negedge clk);
    m_rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      m_wr = vecs[k].wr; m_din = vecs[k].din; m_rd = vecs[k].rd;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d full_n", k), m_full_n, vecs[k].exp_full_n);
      check($sformatf("vec%0d empty_n", k), m_empty_n, vecs[k].exp_empty_n);
      if (vecs[k].exp_empty_n) check($sformatf("vec%0d dout", k), m_dout, vecs[k].exp_dout);
      $display("vec %0d: wr=%0b din=%h rd=%0b -> full_n=%0b empty_n=%0b dout=%h",
               k, m_wr, m_din, m_rd, m_full_n, m_empty_n, m_dout);
      @(negedge clk);
    end

    // Streaming with the reader always ready
    m_reset();
    nxt = 0; got = 0; first_out = -1; last_out = -1; acc0 = -1;
    m_rd = 1'b1;
    for (int cyc = 0; cyc < 3000 && got < 1000; cyc++) begin
      if (m_empty_n) begin
        check($sformatf("stream word %0d", got), m_dout, got);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      m_wr = (nxt < 1000); m_din = nxt;
      if (m_wr && m_full_n) begin
        if (nxt == 0) acc0 = cyc;
        nxt++;
      end
      @(negedge clk);
    end
    m_wr = 1'b0; m_rd = 1'b0;
    check("stream count", got, 1000);
    check("stream fill latency", first_out - acc0, 3);
    check("stream span", last_out - first_out, 999);
    $display("stream: %0d words, first out %0d cycles after first accept", got, first_out - acc0);

    // Backpressure: writer always on, reader stalled
    m_reset();
    nxt = 0; got = 0; max_cnt = 0; saw_high = 1'b0; saw_low = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (m_full_n) saw_high = 1'b1;
      else if (saw_high) saw_low = 1'b1;
      if (int'(u_dut.u_fifo.r_count) > max_cnt) max_cnt = int'(u_dut.u_fifo.r_count);
      if (m_empty_n) check("backpressure hold dout", m_dout, 100);
      m_wr = 1'b1; m_din = 100 + nxt;
      if (m_full_n) nxt++;
      @(negedge clk);
    end
    check("backpressure full_n fell", saw_low, 1);
    check("backpressure no overflow", max_cnt <= 8, 1);
    check("backpressure accepted", nxt, 7);
    check("backpressure final count", u_dut.u_fifo.r_count, 7);
    m_wr = 1'b0; m_rd = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 7; cyc++) begin
      if (m_empty_n) begin
        check($sformatf("drain word %0d", got), m_dout, 100 + got);
        got++;
      end
      @(negedge clk);
    end
    m_rd = 1'b0;
    check("backpressure drained", got, 7);
    $display("backpressure: %0d accepted, %0d drained, peak count %0d", nxt, got, max_cnt);

    // Reset pulsed with words buffered and in flight
    m_reset();
    for (int t = 0; t < 10 && !m_full_n; t++) @(negedge clk);
    check("midreset full_n up", m_full_n, 1);
    for (int i = 0; i < 5; i++) begin
      m_wr = 1'b1; m_din = 32'h50 + i;
      @(negedge clk);
    end
    m_wr = 1'b0;
    check("midreset buffered", m_empty_n, 1);
    m_rst_n = 1'b0;
    #1;
    check("midreset empty_n immediate", m_empty_n, 0);
    check("midreset full_n immediate", m_full_n, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_rst_n = 1'b1;
    for (int t = 0; t < 10 && !m_full_n; t++) begin
      check("midreset no stale word", m_empty_n, 0);
      @(negedge clk);
    end
    check("midreset full_n back", m_full_n, 1);
    m_wr = 1'b1; m_din = 32'h77;
    @(negedge clk);
    m_wr = 1'b0;
    for (int t = 0; t < 10 && !m_empty_n; t++) @(negedge clk);
    check("midreset empty_n after", m_empty_n, 1);
    check("midreset first word", m_dout, 32'h77);
    $display("midreset: first word after release = %h", m_dout);

    for (int t = 0; t < 30000 &&
         !(g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done); t++)
      @(negedge clk);
    check("random runs finished",
          g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
